// File: rtl/controle_busca_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM states,
// MIPS opcode constants used by the decoder, and the default reset PC.
package controle_busca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } estado_t;

  localparam logic [5:0]  OP_J         = 6'b000010;
  localparam logic [5:0]  OP_BEQ       = 6'b000100;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/calc_proximo_pc.sv
// Combinational next-PC selection: jump target, beq target or PC+4.
module calc_proximo_pc (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch_taken,
  output logic [31:0] pc4,
  output logic [31:0] next_pc
);

  logic [31:0] desloc;
  logic        unused_op;

  assign pc4    = pc + 32'd4;
  assign desloc = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Opcode bits are decoded upstream into jump/branch_taken.
  assign unused_op = ^instr[31:26];

  always_comb begin
    next_pc = pc4;
    if (jump) begin
      next_pc = {pc4[31:28], instr[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc4 + desloc;
    end
  end

endmodule

// File: rtl/controle_busca.sv
// Instruction-fetch sequencer: boot-loads instruction memory over a
// valid/ready stream, then runs the PC with stall/halt and commit gating.
module controle_busca
  import controle_busca_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  input  logic              run_start,
  input  logic              halt_req,
  input  logic              stall,
  input  logic [31:0]       instr,
  input  logic              branch_taken,
  input  logic              jump,
  output logic [31:0]       pc,
  output logic              pc_en,
  output logic              running,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata
);

  estado_t           state, state_d;
  logic [ADDR_W-1:0] load_cnt;
  logic              done_q;
  logic              accept;
  logic              load_fim;
  logic              entra_load;
  logic [31:0]       next_pc;
  logic [31:0]       pc4_unused;

  calc_proximo_pc u_calc (
    .pc          (pc),
    .instr       (instr),
    .jump        (jump),
    .branch_taken(branch_taken),
    .pc4         (pc4_unused),
    .next_pc     (next_pc)
  );

  assign load_ready = (state == ST_LOAD);
  assign accept     = load_valid & load_ready;
  // A full memory ends the load even without load_last; the counter never wraps.
  assign load_fim   = accept & (load_last | (load_cnt == {ADDR_W{1'b1}}));
  assign entra_load = (state != ST_LOAD) && (state_d == ST_LOAD);

  assign imem_we    = accept;
  assign imem_waddr = load_cnt;
  assign imem_wdata = load_data;

  assign running    = (state == ST_RUN);
  assign pc_en      = running & ~stall & ~halt_req;
  assign load_done  = done_q;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    unique case (state)
      ST_IDLE, ST_HALTED: begin
        if (load_start)     state_d = ST_LOAD;
        else if (run_start) state_d = ST_RUN;
      end
      ST_LOAD: begin
        if (load_fim) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (halt_req) state_d = ST_HALTED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      load_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state  <= state_d;
      done_q <= load_fim;
      if (entra_load) begin
        load_cnt <= '0;
        pc       <= RESET_PC;
      end else begin
        if (accept) load_cnt <= load_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (pc_en)  pc       <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_controle_busca.sv
// Self-checking bench for controle_busca: directed scenarios plus a random
// run phase, all compared against a behavioural model of the sequencer.
module tb_controle_busca;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start, load_valid, load_last;
  logic [31:0] load_data;
  logic        load_ready, load_done;
  logic        run_start, halt_req, stall;
  logic [31:0] instr;
  logic        branch_taken, jump;
  logic [31:0] pc;
  logic        pc_en, running, imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;

  int vectors = 0;
  int miscompares = 0;

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;
  int          m_mode;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_done;

  controle_busca #(.ADDR_W(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .run_start(run_start), .halt_req(halt_req), .stall(stall),
    .instr(instr), .branch_taken(branch_taken), .jump(jump),
    .pc(pc), .pc_en(pc_en), .running(running),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    load_start = 0; load_valid = 0; load_last = 0; load_data = 0;
    run_start = 0; halt_req = 0; stall = 0; instr = 0;
    branch_taken = 0; jump = 0;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 32'h0; m_cnt = 0; m_done = 0;
  endtask

  // Compare every output against what the model predicts for this cycle.
  task automatic check_outs();
    bit acc;
    acc = (m_mode == M_LOAD) && load_valid;
    check("pc", pc, m_pc);
    check("pc_en", 32'(pc_en), 32'((m_mode == M_RUN) && !stall && !halt_req));
    check("running", 32'(running), 32'(m_mode == M_RUN));
    check("load_ready", 32'(load_ready), 32'(m_mode == M_LOAD));
    check("imem_we", 32'(imem_we), 32'(acc));
    check("load_done", 32'(load_done), 32'(m_done));
    if (acc) begin
      check("imem_waddr", 32'(imem_waddr), 32'(m_cnt));
      check("imem_wdata", imem_wdata, load_data);
    end
  endtask

  // Inputs are already set (posedge+1); check, advance the model, clock.
  task automatic step();
    int          nm, nc;
    bit          nd, acc;
    logic [31:0] np, pc4;
    #2;
    check_outs();
    acc = (m_mode == M_LOAD) && load_valid;
    nm = m_mode; nc = m_cnt; np = m_pc; nd = 0;
    case (m_mode)
      M_IDLE, M_HALT: begin
        if (load_start) begin nm = M_LOAD; nc = 0; np = 32'h0; end
        else if (run_start) nm = M_RUN;
      end
      M_LOAD: begin
        if (acc) begin
          nc = m_cnt + 1;
          if (load_last || m_cnt == 255) begin nm = M_IDLE; nd = 1; end
        end
      end
      default: begin
        if (halt_req) nm = M_HALT;
        else if (!stall) begin
          pc4 = m_pc + 32'd4;
          if (jump)              np = {pc4[31:28], instr[25:0], 2'b00};
          else if (branch_taken) np = pc4 + 32'($signed(instr[15:0])) * 32'd4;
          else                   np = pc4;
        end
      end
    endcase
    m_mode = nm; m_cnt = nc; m_pc = np; m_done = nd;
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [31:0] ins, input logic j, input logic br);
    instr = ins; jump = j; branch_taken = br;
    step();
    jump = 0; branch_taken = 0;
  endtask

  initial begin
    clear_in();
    rst_n = 0;
    #1;
    model_reset();
    check_outs();
    @(posedge clk); #1;
    rst_n = 1;

    // Three-word load, load_valid held, last on word 2.
    load_start = 1; step(); load_start = 0;
    load_valid = 1;
    for (int i = 0; i < 3; i++) begin
      load_data = $urandom; load_last = (i == 2);
      step();
    end
    load_valid = 0; load_last = 0;
    step();
    check("after_load_pc", pc, 32'h0);

    // Straight-line run: 0, 4, 8, 12.
    run_start = 1; step(); run_start = 0;
    for (int i = 0; i < 4; i++) run_op($urandom, 0, 0);
    run_op(32'h12110002, 0, 1);
    check("beq_taken", pc, 32'h1c);
    run_op(32'h08000004, 1, 0);
    run_op(32'h12110002, 0, 0);
    check("beq_not_taken", pc, 32'h14);
    run_op(32'h0800000e, 1, 0);
    run_op(32'h08000000, 1, 1);
    check("jump_over_branch", pc, 32'h0);

    // Halt at 0x08, resume, then stall two cycles.
    run_op(0, 0, 0); run_op(0, 0, 0);
    halt_req = 1; step(); halt_req = 0;
    step();
    check("halted_pc", pc, 32'h8);
    run_start = 1; step(); run_start = 0;
    stall = 1; step(); step(); stall = 0;
    check("stalled_pc", pc, 32'h8);
    run_op(0, 0, 0);

    // Full-memory load without load_last, plus one extra valid word.
    halt_req = 1; step(); halt_req = 0;
    load_start = 1; step(); load_start = 0;
    load_valid = 1;
    for (int i = 0; i < 257; i++) begin
      load_data = $urandom;
      step();
    end
    load_valid = 0;
    step();

    // Reset in the middle of a load.
    load_start = 1; step(); load_start = 0;
    load_valid = 1;
    for (int i = 0; i < 5; i++) begin load_data = $urandom; step(); end
    rst_n = 0;
    #1;
    model_reset();
    check_outs();
    @(posedge clk); #1;
    rst_n = 1;
    load_valid = 0; step();
    load_start = 1; step(); load_start = 0;
    load_valid = 1;
    for (int i = 0; i < 2; i++) begin
      load_data = $urandom; load_last = (i == 1);
      step();
    end
    load_valid = 0; load_last = 0;
    step();

    // Random run phase.
    run_start = 1; step();
    for (int i = 0; i < 400; i++) begin
      run_start    = ($urandom_range(0, 9) < 3);
      halt_req     = ($urandom_range(0, 9) == 0);
      stall        = ($urandom_range(0, 9) < 2);
      jump         = ($urandom_range(0, 9) < 2);
      branch_taken = ($urandom_range(0, 9) < 3);
      load_valid   = $urandom_range(0, 1);
      load_data    = $urandom;
      instr        = $urandom;
      step();
    end
    clear_in();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/controle_busca.md
Name: controle_busca

Overview:
- Instruction-fetch sequencer for the single-cycle MIPS core; owns the PC and the instruction memory write port.
- Boot loader: accepts a stream of 32-bit words over a valid/ready handshake and writes them into the instruction memory from word 0.
- Run mode: computes next-PC (PC+4 / beq / j) and issues a per-cycle commit enable that the datapath uses to gate register-file and data-memory writes.

Parameters:
- ADDR_W, 8, instruction memory word-index width (depth = 2**ADDR_W = 256).
- RESET_PC, 32'h0000_0000, PC value after reset and after every completed load.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  one-cycle request to enter LOAD
- load_valid  in  1  load word present
- load_data  in  32  load word
- load_last  in  1  qualifies the final load word
- load_ready  out  1  block accepts a load word this cycle
- load_done  out  1  one-cycle pulse, load finished
- run_start  in  1  begin or resume execution
- halt_req  in  1  stop execution
- stall  in  1  hold PC this cycle (RUN only)
- instr  in  32  instruction read at pc (combinational memory read)
- branch_taken  in  1  beq condition true (from the ALU zero flag and the decoder)
- jump  in  1  decoded j instruction
- pc  out  32  current PC, drives the memory read address
- pc_en  out  1  commit enable for the current instruction
- running  out  1  state == RUN
- imem_we  out  1  instruction memory write enable
- imem_waddr  out  ADDR_W  word index for the write
- imem_wdata  out  32  write data

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = IDLE, pc = RESET_PC, load_cnt = 0.
  - load_ready = load_done = pc_en = running = imem_we = 0.
- States: IDLE, LOAD, RUN, HALTED. All transitions occur on the clock edge.
- IDLE:
  - pc holds.
  - load_start -> LOAD; else run_start -> RUN.
  - If both are asserted, load_start wins.
- LOAD:
  - On entry: load_cnt = 0 and pc = RESET_PC.
  - load_ready = 1.
  - Accept = load_valid & load_ready. On accept, in the same cycle (combinational): imem_we = 1, imem_waddr = load_cnt, imem_wdata = load_data. load_cnt increments on the edge.
  - End of load on accept with load_last = 1, or on accept at load_cnt == 2**ADDR_W-1 (memory full; no wrap). Next state is IDLE; load_done pulses 1 in the first IDLE cycle.
  - load_start, run_start, halt_req and stall are ignored in LOAD.
  - load_valid outside LOAD is ignored; imem_we stays 0.
- RUN:
  - pc_en = ~stall & ~halt_req.
  - next-PC priority: halt_req or stall -> hold; jump -> {pc4[31:28], instr[25:0], 2'b00}; branch_taken -> pc4 + {{14{instr[15]}}, instr[15:0], 2'b00}; else pc4. Here pc4 = pc + 4.
  - All arithmetic is 32-bit modulo 2**32. Only pc[ADDR_W+1:2] addresses memory, so the PC wraps naturally.
  - halt_req -> HALTED. The instruction at pc is not committed (pc_en = 0) and is re-executed on resume.
  - stall is ignored when halt_req = 1.
- HALTED:
  - pc holds, pc_en = 0.
  - run_start -> RUN, resuming at the held pc.
  - load_start -> LOAD; load wins over run_start.
- pc_en is 0 in every state except RUN.
- pc[1:0] is always 00.
- Reset asserted mid-LOAD: partial contents remain in memory, the counter clears, and no load_done pulse is produced.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, RUN, HALTED), MIPS opcode constants (OP_J = 6'b000010, OP_BEQ = 6'b000100) for the decoder, and RESET_PC default.
- One natural sub-module, calc_proximo_pc: combinational next-PC mux (pc, instr, jump, branch_taken -> pc4, next_pc).

Test Plan:
- Reset then load 3 words (word 2 with load_last), load_valid held high -> imem_we for 3 cycles at waddr 0, 1, 2; load_done pulse 1 cycle later; state IDLE; pc = 0.
- run_start with no branch or jump for 4 cycles -> pc sequence 0, 4, 8, 12; pc_en = 1 each cycle.
- At pc = 0x10 with instr = 0x12110002 (beq) and branch_taken = 1 -> next pc = 0x1C. Same instruction with branch_taken = 0 -> next pc = 0x14.
- At pc = 0x38 with instr = 0x08000000 (j 0) and jump = 1 -> next pc = 0x00. Jump and branch_taken asserted together -> the jump target is taken.
- halt_req at pc = 0x08 -> pc_en = 0, state HALTED, pc holds at 0x08. run_start -> execution resumes at 0x08. stall for 2 cycles -> pc unchanged, pc_en = 0.
- Stream 256 words without load_last -> the last write is at waddr 255, then load_done, then IDLE. A 257th load_valid is not accepted (load_ready = 0).
- rst_n low mid-load after 5 words -> outputs clear immediately; the next load restarts at waddr 0.
